// File: rtl/connect4_win_scanner_if.sv
// Request/result bundle between the game controller and the Connect-4 win scanner.
interface connect4_win_scanner_if;
    logic        start;
    logic [83:0] board_in;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic        draw;
    logic [2:0]  win_row;
    logic [2:0]  win_col;
    logic [1:0]  win_dir;

    modport master (
        output start, board_in,
        input  busy, done, winner, draw, win_row, win_col, win_dir
    );

    modport slave (
        input  start, board_in,
        output busy, done, winner, draw, win_row, win_col, win_dir
    );
endinterface

// File: rtl/connect4_win_scanner.sv
// Scans a captured 6x7 Connect-4 board one anchor cell per clock, row-major,
// and reports the first four-in-a-row found (or a draw on a full board).
module connect4_win_scanner (
    input  logic                         clk,
    input  logic                         reset,
    connect4_win_scanner_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state;
    logic [83:0] snapshot;
    logic [2:0]  row_cnt;
    logic [2:0]  col_cnt;
    logic        busy_q;
    logic        done_q;
    logic        draw_q;
    logic [1:0]  winner_q;
    logic [2:0]  win_row_q;
    logic [2:0]  win_col_q;
    logic [1:0]  win_dir_q;

    int          anchor_r;
    int          anchor_c;
    logic        h_ok, v_ok, dr_ok, ur_ok;
    logic [7:0]  h_line, v_line, dr_line, ur_line;
    logic        hit;
    logic [1:0]  hit_dir;
    logic [1:0]  hit_player;
    logic        board_full;

    // Off-board coordinates read as empty, so no line can reach past the edge.
    function automatic logic [1:0] cell_at(input logic [83:0] b, input int r, input int c);
        logic [1:0] v;
        logic [6:0] idx;
        v   = 2'b00;
        idx = 7'd0;
        if (r >= 0 && r <= 5 && c >= 0 && c <= 6) begin
            idx = 7'((r * 7 + c) * 2);
            v   = b[idx +: 2];
        end
        return (v == 2'b11) ? 2'b00 : v;
    endfunction

    function automatic logic four_same(input logic [7:0] l);
        return (l[1:0] != 2'b00) && (l[1:0] == l[3:2]) &&
               (l[1:0] == l[5:4]) && (l[1:0] == l[7:6]);
    endfunction

    always_comb begin
        anchor_r = int'(row_cnt);
        anchor_c = int'(col_cnt);
        h_ok  = (col_cnt <= 3'd3);
        v_ok  = (row_cnt <= 3'd2);
        dr_ok = h_ok && v_ok;
        ur_ok = h_ok && (row_cnt >= 3'd3);

        h_line  = 8'd0;
        v_line  = 8'd0;
        dr_line = 8'd0;
        ur_line = 8'd0;
        if (h_ok)
            h_line  = {cell_at(snapshot, anchor_r,     anchor_c + 3),
                       cell_at(snapshot, anchor_r,     anchor_c + 2),
                       cell_at(snapshot, anchor_r,     anchor_c + 1),
                       cell_at(snapshot, anchor_r,     anchor_c)};
        if (v_ok)
            v_line  = {cell_at(snapshot, anchor_r + 3, anchor_c),
                       cell_at(snapshot, anchor_r + 2, anchor_c),
                       cell_at(snapshot, anchor_r + 1, anchor_c),
                       cell_at(snapshot, anchor_r,     anchor_c)};
        if (dr_ok)
            dr_line = {cell_at(snapshot, anchor_r + 3, anchor_c + 3),
                       cell_at(snapshot, anchor_r + 2, anchor_c + 2),
                       cell_at(snapshot, anchor_r + 1, anchor_c + 1),
                       cell_at(snapshot, anchor_r,     anchor_c)};
        if (ur_ok)
            ur_line = {cell_at(snapshot, anchor_r - 3, anchor_c + 3),
                       cell_at(snapshot, anchor_r - 2, anchor_c + 2),
                       cell_at(snapshot, anchor_r - 1, anchor_c + 1),
                       cell_at(snapshot, anchor_r,     anchor_c)};

        // Every line starts at the anchor, so the anchor cell names the winner.
        hit        = 1'b1;
        hit_dir    = 2'd0;
        hit_player = cell_at(snapshot, anchor_r, anchor_c);
        if (four_same(h_line))
            hit_dir = 2'd0;
        else if (four_same(v_line))
            hit_dir = 2'd1;
        else if (four_same(dr_line))
            hit_dir = 2'd2;
        else if (four_same(ur_line))
            hit_dir = 2'd3;
        else
            hit = 1'b0;
    end

    always_comb begin
        board_full = 1'b1;
        for (int k = 0; k < 42; k++)
            if (cell_at(snapshot, k / 7, k % 7) == 2'b00)
                board_full = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            snapshot  <= '0;
            row_cnt   <= 3'd0;
            col_cnt   <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            draw_q    <= 1'b0;
            winner_q  <= 2'd0;
            win_row_q <= 3'd0;
            win_col_q <= 3'd0;
            win_dir_q <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        snapshot  <= bus.board_in;
                        row_cnt   <= 3'd0;
                        col_cnt   <= 3'd0;
                        busy_q    <= 1'b1;
                        draw_q    <= 1'b0;
                        winner_q  <= 2'd0;
                        win_row_q <= 3'd0;
                        win_col_q <= 3'd0;
                        win_dir_q <= 2'd0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        winner_q  <= hit_player;
                        win_row_q <= row_cnt;
                        win_col_q <= col_cnt;
                        win_dir_q <= hit_dir;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end else if (row_cnt == 3'd5 && col_cnt == 3'd6) begin
                        draw_q <= board_full;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (col_cnt == 3'd6) begin
                        col_cnt <= 3'd0;
                        row_cnt <= row_cnt + 3'd1;
                    end else begin
                        col_cnt <= col_cnt + 3'd1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.draw    = draw_q;
    assign bus.winner  = winner_q;
    assign bus.win_row = win_row_q;
    assign bus.win_col = win_col_q;
    assign bus.win_dir = win_dir_q;

endmodule

// File: tb/tb_connect4_win_scanner.sv
// Bench for connect4_win_scanner: a brute-force line search over the board is
// the reference; directed boards pin known answers, random boards add coverage.
module tb_connect4_win_scanner;

    localparam int STEP_R [4] = '{0, 1, 1, -1};
    localparam int STEP_C [4] = '{1, 0, 1, 1};

    logic clk = 1'b0;
    logic reset;
    int   cycle_count = 0;
    int   tests_run = 0;
    int   fail_count = 0;

    int   tracking;
    int   start_edge;
    int   n;
    int   done_count;
    int   done_seen_cyc;

    int   exp_winner, exp_row, exp_col, exp_dir, exp_draw, exp_done_cyc;

    connect4_win_scanner_if c4_bus();

    connect4_win_scanner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (c4_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int cell_of(input logic [83:0] b, input int r, input int c);
        logic [1:0] v;
        if (r < 0 || r > 5 || c < 0 || c > 6)
            return 0;
        v = b[7'((r * 7 + c) * 2) +: 2];
        return (v == 2'd3) ? 0 : int'(v);
    endfunction

    function automatic logic [83:0] with_cell(input logic [83:0] b, input int r, input int c,
                                              input logic [1:0] v);
        logic [83:0] t;
        t = b;
        t[7'((r * 7 + c) * 2) +: 2] = v;
        return t;
    endfunction

    // Reference: walk anchors in reading order, try each direction in priority order.
    task automatic model_scan(input logic [83:0] b);
        int found;
        int p;
        int ok;
        int filled;
        found = 0;
        exp_winner = 0; exp_row = 0; exp_col = 0; exp_dir = 0; exp_draw = 0;
        exp_done_cyc = 43;
        for (int k = 0; k < 42 && found == 0; k++) begin
            for (int d = 0; d < 4 && found == 0; d++) begin
                p  = cell_of(b, k / 7, k % 7);
                ok = (p != 0);
                for (int i = 1; i < 4; i++)
                    if (cell_of(b, k / 7 + i * STEP_R[d], k % 7 + i * STEP_C[d]) != p)
                        ok = 0;
                if (ok != 0) begin
                    found = 1;
                    exp_winner = p;
                    exp_row = k / 7;
                    exp_col = k % 7;
                    exp_dir = d;
                    exp_done_cyc = k + 2;
                end
            end
        end
        filled = 0;
        for (int k = 0; k < 42; k++)
            if (cell_of(b, k / 7, k % 7) != 0)
                filled++;
        exp_draw = (found == 0 && filled == 42) ? 1 : 0;
    endtask

    function automatic logic [83:0] rand_board();
        logic [83:0] b;
        int density;
        b = '0;
        density = int'($urandom_range(20, 98));
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                if (int'($urandom_range(0, 99)) < density)
                    b = with_cell(b, r, c, ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2);
                else
                    b = with_cell(b, r, c, ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3);
        return b;
    endfunction

    // Cycle n is the period that follows edge n-1, edge 0 being the one that accepts start.
    always @(negedge clk) begin
        if (tracking != 0) begin
            n = cycle_count - start_edge + 1;
            if (n <= 0) begin
                checkOutput("idle_busy", int'(c4_bus.busy), 0);
                checkOutput("idle_done", int'(c4_bus.done), 0);
            end else begin
                checkOutput("busy", int'(c4_bus.busy), (n <= exp_done_cyc) ? 1 : 0);
                checkOutput("done", int'(c4_bus.done), (n == exp_done_cyc) ? 1 : 0);
                checkOutput("winner",  int'(c4_bus.winner),  (n >= exp_done_cyc) ? exp_winner : 0);
                checkOutput("win_row", int'(c4_bus.win_row), (n >= exp_done_cyc) ? exp_row : 0);
                checkOutput("win_col", int'(c4_bus.win_col), (n >= exp_done_cyc) ? exp_col : 0);
                checkOutput("win_dir", int'(c4_bus.win_dir), (n >= exp_done_cyc) ? exp_dir : 0);
                checkOutput("draw",    int'(c4_bus.draw),    (n >= exp_done_cyc) ? exp_draw : 0);
                if (c4_bus.done === 1'b1) begin
                    done_count++;
                    done_seen_cyc = n;
                end
            end
        end
    end

    // One full scan; board_in is scrambled after capture and start may be re-pulsed mid-scan.
    task automatic applyStimulus(input logic [83:0] b, input bit spur);
        int spur_at;
        @(posedge clk); #2;
        c4_bus.board_in = b;
        c4_bus.start    = 1'b1;
        model_scan(b);
        done_count    = 0;
        done_seen_cyc = -1;
        start_edge    = cycle_count + 1;
        tracking      = 1;
        spur_at = (exp_done_cyc > 2) ? int'($urandom_range(1, exp_done_cyc - 1)) : 1;
        for (int i = 1; i <= exp_done_cyc + 1; i++) begin
            @(posedge clk); #2;
            c4_bus.start    = (spur && i == spur_at && i < exp_done_cyc) ? 1'b1 : 1'b0;
            c4_bus.board_in = rand_board();
        end
        c4_bus.start = 1'b0;
    endtask

    task automatic check_result(input string name, input int w, input int r, input int c,
                                input int d, input int dr, input int cyc);
        checkOutput({name, "_winner"},   int'(c4_bus.winner),  w);
        checkOutput({name, "_row"},      int'(c4_bus.win_row), r);
        checkOutput({name, "_col"},      int'(c4_bus.win_col), c);
        checkOutput({name, "_dir"},      int'(c4_bus.win_dir), d);
        checkOutput({name, "_draw"},     int'(c4_bus.draw),    dr);
        checkOutput({name, "_done_cyc"}, done_seen_cyc,        cyc);
        checkOutput({name, "_done_cnt"}, done_count,           1);
    endtask

    task automatic check_all_zero(input string name);
        checkOutput({name, "_busy"},    int'(c4_bus.busy),    0);
        checkOutput({name, "_done"},    int'(c4_bus.done),    0);
        checkOutput({name, "_winner"},  int'(c4_bus.winner),  0);
        checkOutput({name, "_draw"},    int'(c4_bus.draw),    0);
        checkOutput({name, "_win_row"}, int'(c4_bus.win_row), 0);
        checkOutput({name, "_win_col"}, int'(c4_bus.win_col), 0);
        checkOutput({name, "_win_dir"}, int'(c4_bus.win_dir), 0);
    endtask

    initial begin
        logic [83:0] b;
        reset           = 1'b0;
        c4_bus.start    = 1'b0;
        c4_bus.board_in = '0;
        tracking        = 0;
        start_edge      = 0;
        done_count      = 0;
        done_seen_cyc   = -1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #2;
        reset = 1'b1;

        applyStimulus('0, 1'b0);
        check_result("empty", 0, 0, 0, 0, 0, 43);

        b = '0;
        for (int c = 2; c <= 5; c++) b = with_cell(b, 5, c, 2'd1);
        applyStimulus(b, 1'b0);
        check_result("row5", 1, 5, 2, 0, 0, 39);

        b = '0;
        for (int i = 0; i < 4; i++) b = with_cell(b, 2 + i, i, 2'd2);
        for (int r = 2; r <= 5; r++) b = with_cell(b, r, 6, 2'd1);
        applyStimulus(b, 1'b0);
        check_result("diag_dr", 2, 2, 0, 2, 0, 16);

        b = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                b = with_cell(b, r, c, ((((c / 2) % 2) == 0) != ((r % 2) == 1)) ? 2'd1 : 2'd2);
        applyStimulus(b, 1'b1);
        check_result("draw", 0, 0, 0, 0, 1, 43);

        b = '0;
        for (int i = 0; i < 4; i++) b = with_cell(b, 3 - i, i, 2'd1);
        applyStimulus(b, 1'b1);
        check_result("diag_ur", 1, 3, 0, 3, 0, 23);

        b = '0;
        for (int i = 0; i < 4; i++) b = with_cell(b, 0, i, 2'd1);
        for (int i = 1; i < 4; i++) b = with_cell(b, i, 0, 2'd1);
        applyStimulus(b, 1'b0);
        check_result("priority", 1, 0, 0, 0, 0, 2);

        b = '1;
        applyStimulus(b, 1'b0);
        check_result("code11", 0, 0, 0, 0, 0, 43);

        // Abort a scan partway through; it must never signal done.
        b = '0;
        for (int c = 2; c <= 5; c++) b = with_cell(b, 5, c, 2'd1);
        @(posedge clk); #2;
        tracking        = 0;
        c4_bus.board_in = b;
        c4_bus.start    = 1'b1;
        @(posedge clk); #2;
        c4_bus.start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            checkOutput("abort_no_done", int'(c4_bus.done), 0);
            checkOutput("abort_busy", int'(c4_bus.busy), 1);
        end
        @(posedge clk); #2;
        reset        = 1'b0;
        c4_bus.start = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("abort");
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset_start_busy", int'(c4_bus.busy), 0);
            checkOutput("reset_start_done", int'(c4_bus.done), 0);
        end
        @(posedge clk); #2;
        reset        = 1'b1;
        c4_bus.start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("post_abort_busy", int'(c4_bus.busy), 0);
            checkOutput("post_abort_done", int'(c4_bus.done), 0);
        end
        applyStimulus(b, 1'b1);
        check_result("after_abort", 1, 5, 2, 0, 0, 39);

        for (int t = 0; t < 25; t++) begin
            applyStimulus(rand_board(), ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
            checkOutput("rand_done_cnt", done_count, 1);
        end

        @(posedge clk); #2;
        tracking = 0;
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
